serial_frame_tx: RTL



---
 rtl/serial_frame_tx.sv | 131 +++++++++++++
 1 files changed

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial framing transmitter.
// Each accepted word goes out on s_out as one frame: start bit (0), WIDTH
// data bits, an optional even-parity bit, then a stop bit (1). Every bit is
// held for CLKS_PER_BIT clocks. The line idles high. All line outputs are
// registered so s_out never glitches.

module serial_frame_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int MSB_FIRST    = 0,
    parameter int PARITY_EN    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             s_out,
    output logic             s_valid,
    output logic             busy,
    output logic             done
);

    // Counter widths stay at least one bit so CLKS_PER_BIT=1 and WIDTH=1 work
    localparam int BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int ICW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(CLKS_PER_BIT - 1);
    localparam logic [ICW-1:0] IDX_LAST = ICW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic             par;
    logic [BCW-1:0]   bit_cnt;
    logic [ICW-1:0]   idx_cnt;
    logic             bit_end;
    logic             next_bit;
    logic [WIDTH-1:0] shreg_shifted;

    assign in_ready = (state == IDLE) & ~rst;
    assign bit_end  = (bit_cnt == BIT_LAST);

    // Pick the bit to present next and the register after it has been consumed
    always_comb begin
        next_bit      = shreg[0];
        shreg_shifted = shreg >> 1;
        if (MSB_FIRST != 0) begin
            next_bit      = shreg[WIDTH-1];
            shreg_shifted = shreg << 1;
        end
    end

    // Frame sequencer: accept a word, then step through START/DATA/PARITY/STOP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            par     <= 1'b0;
            bit_cnt <= '0;
            idx_cnt <= '0;
            s_out   <= 1'b1;
            s_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                bit_cnt <= '0;
                idx_cnt <= '0;
                if (in_valid && in_ready) begin
                    shreg   <= in_data;
                    par     <= (PARITY_EN != 0) ? ^in_data : 1'b0;
                    state   <= START;
                    s_out   <= 1'b0;
                    s_valid <= 1'b1;
                    busy    <= 1'b1;
                end
            end else if (!bit_end) begin
                bit_cnt <= bit_cnt + 1'b1;
            end else begin
                bit_cnt <= '0;
                unique case (state)
                    START: begin
                        state   <= DATA;
                        idx_cnt <= '0;
                        s_out   <= next_bit;
                        shreg   <= shreg_shifted;
                    end
                    DATA: begin
                        if (idx_cnt != IDX_LAST) begin
                            idx_cnt <= idx_cnt + 1'b1;
                            s_out   <= next_bit;
                            shreg   <= shreg_shifted;
                        end else if (PARITY_EN != 0) begin
                            state <= PARITY;
                            s_out <= par;
                        end else begin
                            state <= STOP;
                            s_out <= 1'b1;
                        end
                    end
                    PARITY: begin
                        state <= STOP;
                        s_out <= 1'b1;
                    end
                    STOP: begin
                        state   <= IDLE;
                        s_out   <= 1'b1;
                        s_valid <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                    default: begin
                        state   <= IDLE;
                        s_out   <= 1'b1;
                        s_valid <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
